// File: rtl/exec_unit_pipe_if.sv
// Operand/result bundle interface for exec_unit_pipe.
// Handshake: a transfer happens on a rising clock edge where valid && ready are both high;
// the sender holds valid (and its data) until then, the receiver may raise ready at any time.
interface exec_unit_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  src1;
    logic [WIDTH-1:0]  src2;
    logic [WIDTH-1:0]  imm;
    logic [CTRL_W-1:0] control_in;
    logic [WIDTH-1:0]  memory_data_read_in;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  aluout;
    logic              carry;
    logic [WIDTH-1:0]  load_data;
    logic [WIDTH-1:0]  mem_data_write_out;
    logic              mem_write_en;
    logic              illegal_op;

    modport master (
        output in_valid, src1, src2, imm, control_in, memory_data_read_in, out_ready,
        input  in_ready, out_valid, aluout, carry, load_data, mem_data_write_out,
               mem_write_en, illegal_op
    );

    modport slave (
        input  in_valid, src1, src2, imm, control_in, memory_data_read_in, out_ready,
        output in_ready, out_valid, aluout, carry, load_data, mem_data_write_out,
               mem_write_en, illegal_op
    );
endinterface

// File: rtl/exec_unit_pipe.sv
// Handshaked execute stage: registered ALU result, load/store side signals, enable_ex stall.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier for op 10; otherwise op 10 is illegal.
module exec_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable_ex,
    exec_unit_pipe_if.slave bus,
    output logic            state_dbg
);
    localparam int SHW = $clog2(WIDTH);

`ifdef EXEC_MUL_EN
    typedef enum logic [0:0] {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0} state_t;
`endif

    state_t state, state_next;

    logic [3:0]       op;
    logic             use_imm, is_load, is_store, is_mul;
    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res, mul_res;
    logic             alu_carry, alu_illegal, mul_carry;
    logic             accept, mul_done;

    logic             out_valid_q, carry_q, illegal_q, store_q;
    logic [WIDTH-1:0] aluout_q, load_data_q, mem_data_q;

    assign op       = bus.control_in[3:0];
    assign use_imm  = bus.control_in[4];
    assign is_load  = bus.control_in[5];
    assign is_store = bus.control_in[6];
    assign a        = bus.src1;
    assign b        = use_imm ? bus.imm : bus.src2;
    assign shamt    = b[SHW-1:0];
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    assign bus.in_ready = reset && enable_ex && (state == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid          = out_valid_q;
    assign bus.aluout             = aluout_q;
    assign bus.carry              = carry_q;
    assign bus.illegal_op         = illegal_q;
    assign bus.load_data          = load_data_q;
    assign bus.mem_data_write_out = mem_data_q;
    assign bus.mem_write_en       = out_valid_q && bus.out_ready && store_q;
    assign state_dbg              = state;

    // Loads and stores always compute their address as an ADD, whatever the op field says.
    always_comb begin
        alu_res     = '0;
        alu_carry   = 1'b0;
        alu_illegal = 1'b0;
        if (is_load || is_store) begin
            {alu_carry, alu_res} = sum;
        end else begin
            case (op)
                4'd0:    {alu_carry, alu_res} = sum;
                4'd1:    {alu_carry, alu_res} = diff;
                4'd2:    alu_res = a & b;
                4'd3:    alu_res = a | b;
                4'd4:    alu_res = a ^ b;
                4'd5:    alu_res = a << shamt;
                4'd6:    alu_res = a >> shamt;
                4'd7:    alu_res = $signed(a) >>> shamt;
                4'd8:    alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                4'd9:    alu_res = {{(WIDTH-1){1'b0}}, a < b};
                default: alu_illegal = 1'b1;
            endcase
        end
    end

`ifdef EXEC_MUL_EN
    logic [2*WIDTH-1:0] mcand, acc, acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     mul_cnt;

    assign is_mul    = (op == 4'd10) && !is_load && !is_store;
    assign acc_next  = mplier[0] ? acc + mcand : acc;
    // The final step and the result load share one edge, giving WIDTH+1 cycles from accept.
    assign mul_done  = (state == MUL_BUSY) && enable_ex && (mul_cnt == SHW'(WIDTH-1));
    assign mul_res   = acc_next[WIDTH-1:0];
    assign mul_carry = |acc_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand   <= '0;
            acc     <= '0;
            mplier  <= '0;
            mul_cnt <= '0;
        end else if (accept && is_mul) begin
            mcand   <= {{WIDTH{1'b0}}, a};
            acc     <= '0;
            mplier  <= b;
            mul_cnt <= '0;
        end else if (state == MUL_BUSY && enable_ex) begin
            acc     <= acc_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt + SHW'(1);
        end
    end
`else
    assign is_mul    = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_res   = '0;
    assign mul_carry = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
`ifdef EXEC_MUL_EN
            IDLE:     if (accept && is_mul) state_next = MUL_BUSY;
            MUL_BUSY: if (mul_done) state_next = IDLE;
`else
            IDLE:     state_next = IDLE;
`endif
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            aluout_q    <= '0;
            carry_q     <= 1'b0;
            illegal_q   <= 1'b0;
            store_q     <= 1'b0;
            load_data_q <= '0;
            mem_data_q  <= '0;
        end else begin
            if (accept) begin
                load_data_q <= is_load ? bus.memory_data_read_in : '0;
                mem_data_q  <= bus.src2;
                store_q     <= is_store;
                illegal_q   <= alu_illegal && !is_mul;
                if (!is_mul) begin
                    aluout_q <= alu_res;
                    carry_q  <= alu_carry;
                end
            end
            if (mul_done) begin
                aluout_q <= mul_res;
                carry_q  <= mul_carry;
            end
            // A stalled result holds; a handshake clears valid unless a new single-cycle op lands.
            if ((accept && !is_mul) || mul_done) out_valid_q <= 1'b1;
            else if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
        end
    end
endmodule

// File: doc/exec_unit_pipe.md
# exec_unit_pipe

Parametrised, handshaked execute stage that replaces the fixed 32-bit single-cycle execute path of `Processor`. It accepts decoded operands, an immediate and a 7-bit control word, and produces a registered ALU result with carry and the store-side memory signals. It adds valid/ready flow control, an `enable_ex` stall and an optional iterative multiplier. It sits between decode and the memory/writeback stage.

## Interface
- `WIDTH`, 32: datapath width (≥ 8, power of two).
- `CTRL_W`, 7: control word width (fixed encoding below; must be ≥ 7).
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable_ex`  in  1  execute enable; low freezes the block.
- `in_valid`  in  1  operand bundle valid.
- `in_ready`  out  1  block can accept a bundle this cycle.
- `src1`, `src2`  in  WIDTH  register operands A and B.
- `imm`  in  WIDTH  immediate, already sign-extended.
- `control_in`  in  CTRL_W  [3:0] op, [4] use_imm (B=imm), [5] load, [6] store.
- `memory_data_read_in`  in  WIDTH  load data, sampled at accept.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `aluout`  out  WIDTH  result (address for load/store).
- `carry`  out  1  carry flag.
- `load_data`  out  WIDTH  registered load data (0 when not a load).
- `mem_data_write_out`  out  WIDTH  store data (registered `src2`).
- `mem_write_en`  out  1  store strobe.
- `illegal_op`  out  1  op code not implemented, valid with `out_valid`.

## Operation
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL (low WIDTH bits); 11–15 illegal → `aluout`=0, `carry`=0, `illegal_op`=1.
- B = `use_imm` ? `imm` : `src2`. Shift amount = B[$clog2(WIDTH)-1:0].
- ADD: {carry,aluout} = A+B (WIDTH+1 bits). SUB: {carry,aluout} = A+~B+1 (carry=1 means no borrow). MUL: carry = OR of the upper WIDTH product bits. All other ops: carry=0.
- Load/store: aluout = A+B as an ADD; load also registers `memory_data_read_in` into `load_data`.
- FSM: IDLE, MUL_BUSY.
  - IDLE: accept when `in_valid && in_ready`. Non-MUL op: result register loads, `out_valid`=1 next cycle. MUL: go to MUL_BUSY, iteration counter = 0.
  - MUL_BUSY: one shift-add step per enabled cycle. After WIDTH steps, load result, `out_valid`=1, return to IDLE.
- `in_ready` = `enable_ex` && state==IDLE && (!`out_valid` || `out_ready`).
- Output register holds its value while `out_valid && !out_ready`. `out_valid` clears on the handshake unless a new bundle is accepted in the same cycle.
- `mem_write_en` = `out_valid && out_ready && store`, combinational. It is high exactly in the handshake cycle.
- `enable_ex` low: no accept, MUL counter frozen. The output handshake still completes.

## Timing
- Reset (asynchronous): state=IDLE. `out_valid`, `aluout`, `carry`, `load_data`, `mem_data_write_out`, `illegal_op`, counter all 0. `mem_write_en`=0, `in_ready`=0 while reset is asserted.
- Single-cycle ops: latency 1; throughput 1 per cycle when `out_ready` is held high.
- MUL: `out_valid` rises WIDTH+1 enabled cycles after accept. `in_ready`=0 throughout.
- Reset asserted mid-MUL aborts the operation; no result is produced.
- A new MUL is blocked (`in_ready`=0) while a prior result is stalled.

## Configuration
- `EXEC_MUL_EN` defined: op 10 uses the iterative multiplier and the MUL_BUSY state.
- `EXEC_MUL_EN` undefined: no multiplier logic or MUL_BUSY state. Op 10 is illegal (latency 1, `aluout`=0, `illegal_op`=1).

## Test plan
- Reset release, then ADD `src1`=4, `src2`=9, `use_imm`=0 → `aluout`=13, `carry`=0, `out_valid`=1 one cycle after accept.
- ADD `use_imm`=1, `src1`=0xFFFFFFFF, `imm`=1 → `aluout`=0, `carry`=1. SUB 4−9 → `aluout`=0xFFFFFFFB, `carry`=0.
- MUL 0x10000×0x10000 (with `EXEC_MUL_EN`) → after 33 cycles `aluout`=0, `carry`=1, `in_ready`=0 until done. Without the macro → `illegal_op`=1 after 1 cycle.
- Store `src1`=0x100, `imm`=8, `src2`=0xAB with `out_ready` low for 3 cycles → output held, `in_ready`=0. `mem_write_en` pulses only in the cycle `out_ready` rises; `aluout`=0x108, `mem_data_write_out`=0xAB.
- Load with `memory_data_read_in`=15 → `load_data`=15. SRA 0x80000000 by 4 → 0xF8000000. SLT −1<1 → 1.
- Drop `enable_ex` for 5 cycles mid-MUL → completion delayed by exactly 5 cycles. Assert `reset` mid-MUL → `out_valid` stays 0 and the FSM returns to IDLE.
